uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 126 ++++++++++++
 tb/tb_uart_tx_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// Serial transmit engine: start bit, 7 or 8 data bits LSB first, optional parity, one stop bit.
// The configuration and the baud divisor are captured on load and stay fixed for the rest of the frame.
module uart_tx_engine #(
    parameter int DIV_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic             load,
    input  logic [7:0]       out_port,
    output logic             tx,
    output logic             tx_rdy,
    output logic             tx_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_eight;
    logic             r_pen;
    logic             r_par;
    logic             r_tx;
    logic             r_rdy;
    logic             r_done;

    logic [DIV_W-1:0] w_div_eff;
    logic [7:0]       w_data_masked;
    logic             w_par;
    logic             w_bit_end;
    logic [2:0]       w_last_bit;

    // Divisors below 2 would give a zero-length or single-cycle bit; clamp them to 2.
    assign w_div_eff     = (baud_div > DIV_W'(1)) ? baud_div : DIV_W'(2);
    assign w_data_masked = {out_port[7] & eight, out_port[6:0]};
    assign w_par         = (^w_data_masked) ^ ohel;
    assign w_bit_end     = (r_baud_cnt == (r_div - DIV_W'(1)));
    assign w_last_bit    = r_eight ? 3'd7 : 3'd6;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_div      <= DIV_W'(2);
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_eight    <= 1'b0;
            r_pen      <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_rdy      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (load) begin
                    r_shift    <= w_data_masked;
                    r_eight    <= eight;
                    r_pen      <= pen;
                    r_par      <= w_par;
                    r_div      <= w_div_eff;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_tx       <= 1'b0;
                    r_rdy      <= 1'b0;
                    r_state    <= S_START;
                end
            end else if (!w_bit_end) begin
                r_baud_cnt <= r_baud_cnt + DIV_W'(1);
            end else begin
                r_baud_cnt <= '0;
                case (r_state)
                    S_START: begin
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_bit_cnt == w_last_bit) begin
                            if (r_pen) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            // Next data bit comes from the shifted copy so tx stays a plain register.
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_rdy   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx      = r_tx;
    assign tx_rdy  = r_rdy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomized bench for uart_tx_engine: a frame-level reference model feeds a scoreboard queue,
// and a negedge monitor rebuilds each frame from the serial line and compares it.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] baud_div;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic        load;
    logic [7:0]  out_port;
    logic        tx;
    logic        tx_rdy;
    logic        tx_done;

    always #5 clk = ~clk;

    uart_tx_engine #(.DIV_W(19)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .load     (load),
        .out_port (out_port),
        .tx       (tx),
        .tx_rdy   (tx_rdy),
        .tx_done  (tx_done)
    );

    typedef struct {
        logic [10:0] bits;
        int          len;
        int          div;
    } frame_t;

    frame_t exp_q[$];
    int     total = 0;
    int     bad   = 0;
    int     m_busy = 0;
    bit     m_done = 1'b0;
    bit     m_abort = 1'b0;

    task automatic chk(input string name, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    // Frame as a list of line levels: start, data LSB first, optional parity, stop.
    function automatic frame_t make_frame(input int div_raw, input bit e, input bit p,
                                          input bit o, input logic [7:0] d);
        frame_t f;
        int     nd;
        int     idx;
        bit     par;
        nd     = e ? 8 : 7;
        f.bits = '1;
        f.bits[0] = 1'b0;
        par = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f.bits[1+i] = d[i];
            par = par ^ d[i];
        end
        if (o) par = ~par;
        idx = 1 + nd;
        if (p) begin
            f.bits[idx] = par;
            idx++;
        end
        f.bits[idx] = 1'b1;
        f.len = idx + 1;
        f.div = (div_raw < 2) ? 2 : div_raw;
        return f;
    endfunction

    // Reference model: acceptance, busy time and completion pulse at cycle granularity.
    initial begin
        frame_t f;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy  = 0;
                m_done  = 1'b0;
                m_abort = 1'b1;
                exp_q.delete();
            end else begin
                m_done = 1'b0;
                if (m_busy == 0) begin
                    if (load) begin
                        f = make_frame(int'(baud_div), eight, pen, ohel, out_port);
                        exp_q.push_back(f);
                        m_busy = f.len * f.div;
                    end
                end else begin
                    m_busy--;
                    if (m_busy == 0) m_done = 1'b1;
                end
            end
        end
    end

    // Monitor: per-cycle handshake checks plus whole-frame waveform comparison.
    initial begin
        logic   samples[$];
        bit     cap;
        frame_t f;
        int     first_bad;
        cap = 1'b0;
        forever begin
            @(negedge clk);
            if (m_abort) begin
                cap = 1'b0;
                samples.delete();
                m_abort = 1'b0;
            end
            chk("tx_rdy", tx_rdy, (m_busy == 0));
            chk("tx_done", tx_done, m_done);
            if (tx_rdy === 1'b0) begin
                cap = 1'b1;
                samples.push_back(tx);
            end else begin
                chk("idle_tx", tx, 1'b1);
                if (cap) begin
                    if (exp_q.size() == 0) begin
                        chk_int("frame_unexpected", 1, 0);
                    end else begin
                        f = exp_q.pop_front();
                        chk_int("frame_clocks", samples.size(), f.len * f.div);
                        first_bad = -1;
                        if (samples.size() == f.len * f.div) begin
                            for (int k = 0; k < samples.size(); k++)
                                if (first_bad < 0 && samples[k] !== f.bits[k / f.div])
                                    first_bad = k;
                        end
                        chk_int("frame_wave_first_bad_clock", first_bad, -1);
                        $display("frame len=%0d div=%0d bits=%b clocks=%0d",
                                 f.len, f.div, f.bits, samples.size());
                    end
                    samples.delete();
                    cap = 1'b0;
                end
            end
        end
    end

    task automatic scramble();
        baud_div = 19'($urandom_range(0, 7));
        eight    = 1'($urandom);
        pen      = 1'($urandom);
        ohel     = 1'($urandom);
        out_port = 8'($urandom);
    endtask

    // Waits for the model to go idle while wiggling inputs that must not disturb the frame.
    task automatic wait_idle();
        int guard = 0;
        while (m_busy != 0 && guard < 5000) begin
            @(negedge clk);
            load = 1'b0;
            scramble();
            guard++;
        end
        if (guard >= 5000) chk_int("wait_idle_timeout", guard, 0);
    endtask

    task automatic send(input int d, input bit e, input bit p, input bit o, input logic [7:0] v);
        wait_idle();
        baud_div = 19'(d);
        eight    = e;
        pen      = p;
        ohel     = o;
        out_port = v;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; baud_div = 19'd4;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; out_port = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_rdy", tx_rdy, 1'b1);
        chk("reset_done", tx_done, 1'b0);
        rst = 1'b0;

        send(4, 1, 0, 0, 8'hA5);
        send(3, 0, 1, 0, 8'h83);
        send(2, 1, 1, 1, 8'h00);
        send(0, 1, 0, 0, 8'($urandom));
        send(1, 1, 0, 0, 8'($urandom));

        // Load held high: only the byte present at each ready edge may be sent.
        wait_idle();
        baud_div = 19'd2; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        load = 1'b1;
        repeat (120) begin
            out_port = 8'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
        wait_idle();

        // Reset in the middle of data bit 3, together with a load that must lose to it.
        send(4, 1, 0, 0, 8'h5A);
        repeat (17) @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_rdy", tx_rdy, 1'b1);
        chk("abort_done", tx_done, 1'b0);
        rst  = 1'b0;
        load = 1'b0;
        send(4, 1, 0, 0, 8'hC3);

        repeat (30) send($urandom_range(0, 6), 1'($urandom), 1'($urandom),
                         1'($urandom), 8'($urandom));

        wait_idle();
        repeat (5) @(negedge clk);
        chk_int("pending_frames", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
